// File: rtl/des_pkg.sv
// Shared DES definitions for the iterative encrypt/decrypt cores.
// Contents: fixed DES widths, FSM state type, FIPS 46-3 permutation and
// S-box tables, key-schedule shift tables, and the permutation/rotation
// helper functions. All bit numbering follows FIPS (bit 1 = MSB), so every
// vector carrying DES data is declared with an ascending [1:N] range and
// the table entries can be used directly as indices.
package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int KEY_W    = 64;
  localparam int HALF_W   = 32;
  localparam int CD_W     = 28;
  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;

  typedef enum logic [1:0] {IDLE, ROUND, OUT} state_t;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Index = row*16 + column, row = {b1,b6}, column = b2..b5.
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
       0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
       4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
       3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
       0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
       1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
       3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
       4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
       9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
       4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
       1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
       6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
       1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
       7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
       2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Decrypt walks the schedule backwards: round 1 uses C0/D0 unrotated
  // (C16 == C0), later rounds undo the encrypt left shifts in reverse.
  localparam int DEC_SHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [1:BLOCK_W] ip_perm(input logic [1:BLOCK_W] d);
    logic [1:BLOCK_W] o;
    for (int i = 0; i < BLOCK_W; i++) o[i+1] = d[IP_TBL[i]];
    return o;
  endfunction

  function automatic logic [1:BLOCK_W] fp_perm(input logic [1:BLOCK_W] d);
    logic [1:BLOCK_W] o;
    for (int i = 0; i < BLOCK_W; i++) o[i+1] = d[FP_TBL[i]];
    return o;
  endfunction

  function automatic logic [1:SUBKEY_W] e_expand(input logic [1:HALF_W] d);
    logic [1:SUBKEY_W] o;
    for (int i = 0; i < SUBKEY_W; i++) o[i+1] = d[E_TBL[i]];
    return o;
  endfunction

  function automatic logic [1:HALF_W] p_perm(input logic [1:HALF_W] d);
    logic [1:HALF_W] o;
    for (int i = 0; i < HALF_W; i++) o[i+1] = d[P_TBL[i]];
    return o;
  endfunction

  // Drops the eight parity bits (8, 16, ..., 64) as a side effect.
  function automatic logic [1:2*CD_W] pc1_perm(input logic [1:KEY_W] d);
    logic [1:2*CD_W] o;
    for (int i = 0; i < 2*CD_W; i++) o[i+1] = d[PC1_TBL[i]];
    return o;
  endfunction

  function automatic logic [1:SUBKEY_W] pc2_perm(input logic [1:2*CD_W] d);
    logic [1:SUBKEY_W] o;
    for (int i = 0; i < SUBKEY_W; i++) o[i+1] = d[PC2_TBL[i]];
    return o;
  endfunction

  function automatic logic [1:CD_W] rot28(input logic [1:CD_W] v, input int amt,
                                          input logic left);
    logic [1:CD_W] o;
    for (int i = 0; i < CD_W; i++)
      o[i+1] = left ? v[((i + amt) % CD_W) + 1] : v[((i - amt + CD_W) % CD_W) + 1];
    return o;
  endfunction

  function automatic logic [3:0] sbox(input int box, input logic [5:0] six);
    int idx;
    idx = int'({six[5], six[0]}) * 16 + int'(six[4:1]);
    return 4'(SBOX[box][idx]);
  endfunction

endpackage

// File: rtl/des_decrypt_if.sv
// Block/key input bus and plaintext output handshake of the DES core.
// master: block source + plaintext sink side; slave: the DES core.
// Signals: in_valid/in_ready/desIn/keyIn (input block), out_valid/
// out_ready/desOut (result), busy (core status). With the macro
// DES_DECRYPT_ENC_MODE_EN defined, enc_mode selects encryption per block.
interface des_decrypt_if;
  import des_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [1:BLOCK_W]    desIn;
  logic [1:KEY_W]      keyIn;
  logic                out_valid;
  logic                out_ready;
  logic [1:BLOCK_W]    desOut;
  logic                busy;
`ifdef DES_DECRYPT_ENC_MODE_EN
  logic                enc_mode;

  modport master (output in_valid, desIn, keyIn, out_ready, enc_mode,
                  input  in_ready, out_valid, desOut, busy);
  modport slave  (input  in_valid, desIn, keyIn, out_ready, enc_mode,
                  output in_ready, out_valid, desOut, busy);
`else
  modport master (output in_valid, desIn, keyIn, out_ready,
                  input  in_ready, out_valid, desOut, busy);
  modport slave  (input  in_valid, desIn, keyIn, out_ready,
                  output in_ready, out_valid, desOut, busy);
`endif
endinterface

// File: rtl/des_round_f.sv
// DES Feistel function f(R, K): E expansion, XOR with the round subkey,
// S1..S8 substitution, then P permutation. Purely combinational.
// Ports: r [1:32] right half in, k [1:48] subkey in, f_out [1:32] result.
module des_round_f
  import des_pkg::*;
(
  input  logic [1:HALF_W]   r,
  input  logic [1:SUBKEY_W] k,
  output logic [1:HALF_W]   f_out
);

  logic [1:SUBKEY_W] x;
  logic [1:HALF_W]   s_out;

  always_comb begin
    // NOTE: every variable gets a value before any branch or loop so no
    // path leaves it unassigned, which would otherwise infer a latch.
    x     = e_expand(r) ^ k;
    s_out = '0;
    for (int i = 0; i < 8; i++)
      s_out[4*i+1 +: 4] = sbox(i, x[6*i+1 +: 6]);
    f_out = p_perm(s_out);
  end

endmodule

// File: rtl/des_decrypt.sv
// Iterative DES decryption core: one Feistel round per clock, 16 rounds
// per block, subkeys generated on the fly by right-rotating C/D (K16..K1).
// Ports: clk, rst (async, active-high), bus (des_decrypt_if.slave).
// Optional: DES_DECRYPT_ENC_MODE_EN adds bus.enc_mode, sampled at accept;
// enc_mode=1 rotates left with the forward schedule, i.e. encrypts.
module des_decrypt
  import des_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  des_decrypt_if.slave bus
);

  state_t            state_q, state_d;
  logic [1:HALF_W]   l_q, r_q, f_val, r_next;
  logic [1:CD_W]     c_q, d_q, c_rot, d_rot;
  logic [1:SUBKEY_W] subkey;
  logic [3:0]        round_q;
  logic [1:BLOCK_W]  out_q;
  logic              enc_q;
  logic              last_round;
  logic              in_ready, out_valid, busy;
  int                shift_amt;

  assign last_round = (round_q == 4'(ROUNDS - 1));

  // Rotating first and then applying PC2 gives this round's subkey; the
  // rotated C/D is also what gets stored for the next round.
  always_comb begin
    shift_amt = enc_q ? ENC_SHIFT[round_q] : DEC_SHIFT[round_q];
    c_rot     = rot28(c_q, shift_amt, enc_q);
    d_rot     = rot28(d_q, shift_amt, enc_q);
    subkey    = pc2_perm({c_rot, d_rot});
  end

  des_round_f u_round_f (
    .r     (r_q),
    .k     (subkey),
    .f_out (f_val)
  );

  assign r_next = l_q ^ f_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (bus.in_valid) state_d = ROUND;
      end
      ROUND:   if (last_round) state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef DES_DECRYPT_ENC_MODE_EN
  assign enc_q = 1'b0;
`endif

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others (l_q <= r_q relies on it).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      out_q   <= '0;
`ifdef DES_DECRYPT_ENC_MODE_EN
      enc_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          {l_q, r_q} <= ip_perm(bus.desIn);
          {c_q, d_q} <= pc1_perm(bus.keyIn);
          round_q    <= '0;
`ifdef DES_DECRYPT_ENC_MODE_EN
          enc_q      <= bus.enc_mode;
`endif
        end
        ROUND: begin
          l_q     <= r_q;
          r_q     <= r_next;
          c_q     <= c_rot;
          d_q     <= d_rot;
          round_q <= round_q + 4'd1;
          // Last round: swap halves back ({R16, L16}) before FP.
          if (last_round) out_q <= fp_perm({r_next, r_q});
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.desOut    = out_q;

endmodule

// File: tb/tb_des_decrypt.sv
// Self-checking bench for des_decrypt: known-answer vectors, parity-bit
// insensitivity, output backpressure, back-to-back accept timing, and
// reset in the middle of a block. Expected plaintexts are queued when a
// block is accepted and popped when the core presents its result.
module tb_des_decrypt;

  logic clk = 1'b0;
  logic rst;
  int   edge_cnt = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [63:0] sb_q[$];
  int          acc_q[$];

  localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1  = 64'h85E813540F0AB405;
  localparam logic [63:0] P1  = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
  localparam logic [63:0] C2  = 64'h0000000000000000;
  localparam logic [63:0] P2  = 64'h8787878787878787;
  localparam logic [63:0] PAR = 64'h0101010101010101;
  localparam logic [63:0] C3  = 64'h8CA64DE9C1B123A7;
  localparam logic [63:0] C4  = 64'h7359B2163E4EDC58;
  localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

  des_decrypt_if bus ();

  des_decrypt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Offers a block from the current negedge until accepted; records the
  // accept edge and queues the expected result. Returns one negedge later.
  task automatic send(input string name, input logic [63:0] ct, input logic [63:0] key,
                      input logic [63:0] exp, input bit keep_valid);
    int t;
    bus.in_valid = 1'b1;
    bus.desIn    = ct;
    bus.keyIn    = key;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      $display("FAIL %s_accept: in_ready=%0b after %0d cycles, expected 1", name, bus.in_ready, t);
      bus.in_valid = 1'b0;
      return;
    end
    sb_q.push_back(exp);
    acc_q.push_back(edge_cnt + 1);
    @(negedge clk);
    if (!keep_valid) begin
      bus.in_valid = 1'b0;
      bus.desIn    = ~ct;
      bus.keyIn    = ~key;
    end
  endtask

  // Waits for the result with out_ready=1, checks data, latency and the
  // post-handshake state. hs_edge is the handshake clock edge.
  task automatic collect(input string name, output int hs_edge);
    int t;
    int acc;
    logic [63:0] exp;
    hs_edge = 0;
    bus.out_ready = 1'b1;
    t = 0;
    while (!bus.out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!bus.out_valid || sb_q.size() == 0) begin
      $display("FAIL %s_result: out_valid=%0b pending=%0d, expected a result", name,
               bus.out_valid, sb_q.size());
      return;
    end
    exp = sb_q.pop_front();
    acc = acc_q.pop_front();
    if (bus.desOut !== exp)
      $display("FAIL %s_data: desOut=%h expected %h", name, bus.desOut, exp);
    else n_pass++;
    n_checks++;
    if (edge_cnt - acc != 16)
      $display("FAIL %s_latency: out_valid after %0d edges, expected 16", name, edge_cnt - acc);
    else n_pass++;
    hs_edge = edge_cnt + 1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL %s_release: out_valid=%0b in_ready=%0b, expected 0 1", name,
               bus.out_valid, bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_ctrl: in_ready=%0b out_valid=%0b busy=%0b, expected 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.desOut !== 64'h0)
      $display("FAIL reset_data: desOut=%h expected 0", bus.desOut);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL reset_release: in_ready=%0b busy=%0b, expected 1 0", bus.in_ready, bus.busy);
    else n_pass++;
  endtask

  task automatic test_fips();
    int hs;
    bus.out_ready = 1'b1;
    send("fips", C1, K1, P1, 1'b0);
    collect("fips", hs);
  endtask

  task automatic test_second_vector();
    int hs;
    send("vec2", C2, K2, P2, 1'b0);
    collect("vec2", hs);
    send("vec2_parity", C2, K2 ^ PAR, P2, 1'b0);
    collect("vec2_parity", hs);
  endtask

  task automatic test_more_vectors();
    int hs;
    send("zero_key", C3, 64'h0, 64'h0, 1'b0);
    collect("zero_key", hs);
    send("ones_key", C4, ONES, ONES, 1'b0);
    collect("ones_key", hs);
  endtask

  task automatic test_backpressure();
    int t;
    bit stable;
    bit quiet;
    logic [63:0] exp;
    bus.out_ready = 1'b0;
    send("bp", C1, K1, P1, 1'b0);
    t = 0;
    while (!bus.out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (!bus.out_valid || sb_q.size() == 0) begin
      $display("FAIL bp_valid: out_valid=%0b after %0d cycles, expected 1", bus.out_valid, t);
      sb_q.delete();
      acc_q.delete();
      return;
    end
    n_pass++;
    exp = sb_q.pop_front();
    acc_q.delete();
    // A competing block offered while the result is stalled must be ignored.
    bus.in_valid = 1'b1;
    bus.desIn    = C2;
    bus.keyIn    = K2;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (stable && (bus.out_valid !== 1'b1 || bus.desOut !== exp || bus.in_ready !== 1'b0)) begin
        $display("FAIL bp_hold: out_valid=%0b desOut=%h in_ready=%0b, expected 1 %h 0",
                 bus.out_valid, bus.desOut, bus.in_ready, exp);
        stable = 1'b0;
      end
    end
    n_checks++;
    if (stable) n_pass++;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b, expected 0 1",
               bus.out_valid, bus.in_ready);
    else n_pass++;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (quiet && (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)) begin
        $display("FAIL bp_single: out_valid=%0b busy=%0b, expected 0 0", bus.out_valid, bus.busy);
        quiet = 1'b0;
      end
    end
    n_checks++;
    if (quiet) n_pass++;
  endtask

  task automatic test_back_to_back();
    int hs_a;
    int hs_b;
    bus.out_ready = 1'b1;
    send("b2b_a", C1, K1, P1, 1'b1);
    bus.desIn = C2;
    bus.keyIn = K2;
    collect("b2b_a", hs_a);
    send("b2b_b", C2, K2, P2, 1'b0);
    n_checks++;
    if (acc_q.size() == 0 || acc_q[0] - hs_a != 1)
      $display("FAIL b2b_gap: second accept %0d edges after handshake, expected 1",
               (acc_q.size() == 0) ? -1 : acc_q[0] - hs_a);
    else n_pass++;
    collect("b2b_b", hs_b);
  endtask

  task automatic test_mid_reset();
    int hs;
    bit quiet;
    bus.out_ready = 1'b1;
    send("rst_mid", C1, K1, P1, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.desOut !== 64'h0)
      $display("FAIL rst_mid_abort: in_ready=%0b out_valid=%0b busy=%0b desOut=%h, expected 1 0 0 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.desOut);
    else n_pass++;
    sb_q.delete();
    acc_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (25) begin
      @(negedge clk);
      if (quiet && (bus.out_valid !== 1'b0 || bus.busy !== 1'b0)) begin
        $display("FAIL rst_mid_stale: out_valid=%0b busy=%0b, expected 0 0", bus.out_valid, bus.busy);
        quiet = 1'b0;
      end
    end
    n_checks++;
    if (quiet) n_pass++;
    send("rst_fresh", C2, K2, P2, 1'b0);
    collect("rst_fresh", hs);
  endtask

`ifdef DES_DECRYPT_ENC_MODE_EN
  task automatic test_enc_mode();
    int hs;
    bus.out_ready = 1'b1;
    bus.enc_mode  = 1'b1;
    send("enc_fips", P1, K1, C1, 1'b0);
    bus.enc_mode  = 1'b0;
    collect("enc_fips", hs);
    bus.enc_mode  = 1'b1;
    send("enc_zero", 64'h0, 64'h0, C3, 1'b0);
    bus.enc_mode  = 1'b0;
    collect("enc_zero", hs);
    send("dec_after_enc", C1, K1, P1, 1'b0);
    collect("dec_after_enc", hs);
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.desIn     = '0;
    bus.keyIn     = '0;
`ifdef DES_DECRYPT_ENC_MODE_EN
    bus.enc_mode  = 1'b0;
`endif
    test_reset();
    test_fips();
    test_second_vector();
    test_more_vectors();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
`ifdef DES_DECRYPT_ENC_MODE_EN
    test_enc_mode();
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
